// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache line-refill sequencer.
package icache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 256;
  localparam int OFF_W      = 5;   // byte-offset bits within a 32-byte line
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_WRITE,
    ST_HOLD
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;

  function automatic logic [2:0] beat_cti(input logic [IDX_W-1:0] k);
    return (k == 3'd7) ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: word-addressed single write port, whole line read flat.
module icache_line_buf
  import icache_pkg::*;
#(
  parameter int WORDS = LINE_WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORDS*WORD_W-1:0]  line
);

  logic [WORD_W-1:0] mem [WORDS];

  // NOTE: the array is cleared on reset because its contents drive the cache
  // write-data port directly and must read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign line[g*WORD_W +: WORD_W] = mem[g];
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line-refill sequencer: 8-beat Wishbone burst read into a line buffer,
// then a one-cycle cache write. Define ICACHE_CWF_EN for critical-word-first.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req_i,
  input  logic [ADDR_W-1:0]     miss_addr_i,
  output logic                  freeze_o,
  output logic                  cache_we_o,
  output logic [LINE_W-1:0]     cache_wdata_o,
  output logic [ADDR_W-1:0]     cache_addr_o,
  output logic                  refill_done_o,
  output logic                  refill_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [WORD_W-1:0]     wb_dat_o,
  output logic [ADDR_W-1:0]     wb_adr_o,
  output logic [2:0]            wb_cti_o,
  output logic [1:0]            wb_bte_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic [WORD_W-1:0]     wb_dat_i
);

  state_e               state;
  logic [IDX_W-1:0]     k;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     miss_start;
  logic                 buf_we;
  logic                 unused_bits;

`ifdef ICACHE_CWF_EN
  localparam logic [1:0] BTE_MODE = BTE_WRAP8;
  assign miss_start = miss_addr_i[OFF_W-1:2];
`else
  localparam logic [1:0] BTE_MODE = BTE_LINEAR;
  assign miss_start = '0;
`endif

  assign unused_bits = ^miss_addr_i[OFF_W-1:0];

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_dat_o = '0;

  // Buffer slot follows the beat's address, so the line is ordered by address
  // regardless of the order the beats arrive in.
  assign idx    = start + k;
  assign buf_we = (state == ST_BURST) && wb_stb_o && wb_ack_i && !wb_err_i;

  icache_line_buf #(
    .WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .idx   (idx),
    .wdata (wb_dat_i),
    .line  (cache_wdata_o)
  );

  // NOTE: every output is a flop assigned with non-blocking updates; the
  // one-cycle pulses get a low default at the top so each branch only raises them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      k             <= '0;
      start         <= '0;
      freeze_o      <= 1'b0;
      cache_we_o    <= 1'b0;
      cache_addr_o  <= '0;
      refill_done_o <= 1'b0;
      refill_err_o  <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_adr_o      <= '0;
      wb_cti_o      <= CTI_CLASSIC;
      wb_bte_o      <= BTE_LINEAR;
    end else begin
      cache_we_o    <= 1'b0;
      refill_done_o <= 1'b0;
      refill_err_o  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (miss_req_i) begin
            state        <= ST_BURST;
            k            <= '0;
            start        <= miss_start;
            cache_addr_o <= {miss_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            freeze_o     <= 1'b1;
            wb_cyc_o     <= 1'b1;
            wb_stb_o     <= 1'b1;
            wb_adr_o     <= {miss_addr_i[ADDR_W-1:OFF_W], miss_start, 2'b00};
            wb_cti_o     <= beat_cti('0);
            wb_bte_o     <= BTE_MODE;
          end
        end

        ST_BURST: begin
          if (!wb_stb_o) begin
            // One-cycle strobe gap after a retry; the beat address is unchanged.
            wb_stb_o <= 1'b1;
          end else if (wb_err_i) begin
            state        <= ST_HOLD;
            refill_err_o <= 1'b1;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_cti_o     <= CTI_CLASSIC;
            wb_bte_o     <= BTE_LINEAR;
          end else if (wb_ack_i) begin
            if (k == 3'd7) begin
              state      <= ST_WRITE;
              cache_we_o <= 1'b1;
              wb_cyc_o   <= 1'b0;
              wb_stb_o   <= 1'b0;
              wb_cti_o   <= CTI_CLASSIC;
              wb_bte_o   <= BTE_LINEAR;
            end else begin
              k        <= k + 3'd1;
              wb_adr_o <= {cache_addr_o[ADDR_W-1:OFF_W], idx + 3'd1, 2'b00};
              wb_cti_o <= beat_cti(k + 3'd1);
            end
          end else if (wb_rty_i) begin
            wb_stb_o <= 1'b0;
          end
        end

        ST_WRITE: begin
          state         <= ST_HOLD;
          refill_done_o <= 1'b1;
        end

        ST_HOLD: begin
          state    <= ST_IDLE;
          freeze_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: response plans are expanded into
// a per-cycle expected waveform and compared against the DUT every cycle.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

`ifdef ICACHE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req_i;
  logic [31:0]  miss_addr_i;
  logic         freeze_o, cache_we_o, refill_done_o, refill_err_o;
  logic [255:0] cache_wdata_o;
  logic [31:0]  cache_addr_o;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]   wb_sel_o;
  logic [31:0]  wb_dat_o, wb_adr_o;
  logic [2:0]   wb_cti_o;
  logic [1:0]   wb_bte_o;
  logic         wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0]  wb_dat_i;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_req_i    (miss_req_i),
    .miss_addr_i   (miss_addr_i),
    .freeze_o      (freeze_o),
    .cache_we_o    (cache_we_o),
    .cache_wdata_o (cache_wdata_o),
    .cache_addr_o  (cache_addr_o),
    .refill_done_o (refill_done_o),
    .refill_err_o  (refill_err_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_o      (wb_dat_o),
    .wb_adr_o      (wb_adr_o),
    .wb_cti_o      (wb_cti_o),
    .wb_bte_o      (wb_bte_o),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .wb_rty_i      (wb_rty_i),
    .wb_dat_i      (wb_dat_i)
  );

  typedef enum int {R_ACK, R_WAIT, R_RTY, R_ERR, R_ACKERR} resp_e;

  typedef struct {
    logic        miss;
    logic [31:0] addr;
    logic        ack, err, rty;
    logic [31:0] dat;
  } stim_t;

  typedef struct {
    logic         freeze, cyc, stb, we, done, err, chk_line;
    logic [31:0]  adr, caddr;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic [255:0] line;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  // Reference model: what the cache should eventually see.
  logic [31:0] m_buf [8];
  logic [31:0] m_caddr;
  bit          m_line_ok;
  bit          det_data;

  int errors = 0;
  int checks = 0;
  int cycle_n = 0;
  int t0;
  logic prev_freeze = 1'b0;

  int           we_c[$], done_c[$], err_c[$], fall_c[$];
  logic [31:0]  adr_log[$];
  logic [2:0]   cti_log[$];
  logic [255:0] we_line;
  logic [31:0]  we_caddr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle_n, act, exp);
    end
  endtask

  function automatic logic [255:0] model_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = m_buf[i];
    return l;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{default: '0};
    e.chk_line = m_line_ok;
    e.caddr    = m_caddr;
    e.line     = model_line();
    return e;
  endfunction

  function automatic exp_t busy_exp();
    exp_t e;
    e = '{default: '0};
    e.freeze = 1'b1;
    return e;
  endfunction

  function automatic stim_t quiet_stim();
    stim_t s;
    s = '{default: '0};
    s.addr = $urandom;
    return s;
  endfunction

  // Outside IDLE the miss line may wiggle freely; the DUT must ignore it.
  function automatic stim_t busy_stim();
    stim_t s;
    s = quiet_stim();
    s.miss = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(quiet_stim(), idle_exp());
  endtask

  task automatic clear_logs();
    we_c.delete(); done_c.delete(); err_c.delete(); fall_c.delete();
    adr_log.delete(); cti_log.delete();
    we_line  = '0;
    we_caddr = '0;
  endtask

  // Expand a slave response plan into per-cycle stimulus and expected outputs.
  task automatic plan_refill(input logic [31:0] addr, input resp_e plan[$]);
    stim_t s;
    exp_t  e;
    logic [2:0]  st, idx;
    logic [26:0] base;
    int k;
    k    = 0;
    st   = CWF ? addr[4:2] : 3'd0;
    base = addr[31:5];
    s = quiet_stim();
    s.miss = 1'b1;
    s.addr = addr;
    push(s, idle_exp());
    m_line_ok = 0;
    m_caddr   = {base, 5'b0};
    foreach (plan[p]) begin
      idx = st + 3'(k);
      e = busy_exp();
      e.cyc = 1'b1;
      e.stb = 1'b1;
      e.adr = {base, idx, 2'b00};
      e.cti = (k == 7) ? 3'b111 : 3'b010;
      e.bte = CWF ? 2'b10 : 2'b00;
      s = busy_stim();
      s.dat = det_data ? ((plan[p] == R_ACK) ? (32'hBEA7_0000 | 32'(p)) : 32'hDEAD_BEEF) : $urandom;
      case (plan[p])
        R_ACK:    begin s.ack = 1'b1; m_buf[idx] = s.dat; k++; end
        R_WAIT:   ;
        R_RTY:    s.rty = 1'b1;
        R_ERR:    s.err = 1'b1;
        R_ACKERR: begin s.err = 1'b1; s.ack = 1'b1; end
      endcase
      push(s, e);
      if (plan[p] == R_RTY) begin
        e = busy_exp();
        e.cyc = 1'b1;
        push(busy_stim(), e);
      end
      if (plan[p] == R_ERR || plan[p] == R_ACKERR) begin
        e = busy_exp();
        e.err = 1'b1;
        push(busy_stim(), e);
        return;
      end
      if (k == 8) begin
        e = busy_exp();
        e.we       = 1'b1;
        e.chk_line = 1'b1;
        e.caddr    = m_caddr;
        e.line     = model_line();
        push(busy_stim(), e);
        e.we   = 1'b0;
        e.done = 1'b1;
        push(busy_stim(), e);
        m_line_ok = 1;
        return;
      end
    end
  endtask

  task automatic random_plan(output resp_e plan[$]);
    int acks, err_beat, r;
    acks = 0;
    plan.delete();
    err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
    while (acks < 8) begin
      r = int'($urandom_range(0, 99));
      if (acks == err_beat && r < 30) begin
        plan.push_back((r < 10) ? R_ACKERR : R_ERR);
        break;
      end else if (r < 20) plan.push_back(R_WAIT);
      else if (r < 30) plan.push_back(R_RTY);
      else begin
        plan.push_back(R_ACK);
        acks++;
      end
    end
  endtask

  task automatic apply_stim(input stim_t s);
    miss_req_i  = s.miss;
    miss_addr_i = s.addr;
    wb_ack_i    = s.ack;
    wb_err_i    = s.err;
    wb_rty_i    = s.rty;
    wb_dat_i    = s.dat;
  endtask

  // The compare process: one expected record per clock, sampled mid-cycle.
  task automatic run_cycles(input int n);
    exp_t  e;
    stim_t s;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      check("freeze_o", freeze_o, e.freeze);
      check("wb_cyc_o", wb_cyc_o, e.cyc);
      check("wb_stb_o", wb_stb_o, e.stb);
      check("cache_we_o", cache_we_o, e.we);
      check("refill_done_o", refill_done_o, e.done);
      check("refill_err_o", refill_err_o, e.err);
      check("wb_const", {wb_we_o, wb_sel_o, wb_dat_o}, {1'b0, 4'hF, 32'h0});
      if (e.stb) begin
        check("wb_adr_o", wb_adr_o, e.adr);
        check("wb_cti_o", wb_cti_o, e.cti);
        check("wb_bte_o", wb_bte_o, e.bte);
      end
      if (e.chk_line) begin
        check("cache_addr_o", cache_addr_o, e.caddr);
        check("cache_wdata_o", cache_wdata_o, e.line);
      end
      if (wb_stb_o) begin
        adr_log.push_back(wb_adr_o);
        cti_log.push_back(wb_cti_o);
      end
      if (cache_we_o) begin
        we_c.push_back(cycle_n);
        we_line  = cache_wdata_o;
        we_caddr = cache_addr_o;
      end
      if (refill_done_o) done_c.push_back(cycle_n);
      if (refill_err_o) err_c.push_back(cycle_n);
      if (prev_freeze && !freeze_o) fall_c.push_back(cycle_n);
      prev_freeze = freeze_o;
      apply_stim(s);
      cycle_n++;
    end
  endtask

  task automatic run_all();
    run_cycles(exp_q.size());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freeze"}, freeze_o, 1'b0);
    check({tag, "_cyc_stb"}, {wb_cyc_o, wb_stb_o}, 2'b00);
    check({tag, "_pulses"}, {cache_we_o, refill_done_o, refill_err_o}, 3'b000);
    check({tag, "_adr"}, wb_adr_o, 32'h0);
    check({tag, "_cti_bte"}, {wb_cti_o, wb_bte_o}, 5'b0);
    check({tag, "_caddr"}, cache_addr_o, 32'h0);
    check({tag, "_wdata"}, cache_wdata_o, 256'h0);
    check({tag, "_sel"}, wb_sel_o, 4'hF);
  endtask

  initial begin
    resp_e plan[$];
    apply_stim('{default: '0});
    for (int i = 0; i < 8; i++) m_buf[i] = '0;
    m_caddr   = '0;
    m_line_ok = 1;
    det_data  = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    push_idle(2);
    run_all();

    // Zero-wait refill at 0x1234.
    clear_logs();
    t0 = cycle_n;
    plan.delete();
    for (int i = 0; i < 8; i++) plan.push_back(R_ACK);
    plan_refill(32'h0000_1234, plan);
    push_idle(3);
    run_all();
    check("t1_beats", adr_log.size(), 8);
    check("t1_adr0", adr_log[0], CWF ? 32'h1234 : 32'h1220);
    check("t1_adr3", adr_log[3], CWF ? 32'h1220 : 32'h122C);
    check("t1_adr7", adr_log[7], CWF ? 32'h1230 : 32'h123C);
    check("t1_cti6", cti_log[6], 3'b010);
    check("t1_cti7", cti_log[7], 3'b111);
    check("t1_we_lat", we_c.size() > 0 ? we_c[0] - t0 : -1, 9);
    check("t1_done_lat", done_c.size() > 0 ? done_c[0] - t0 : -1, 10);
    check("t1_fall_lat", fall_c.size() > 0 ? fall_c[0] - t0 : -1, 11);
    check("t1_caddr", we_caddr, 32'h1220);
    check("t1_first_word", CWF ? we_line[191:160] : we_line[31:0], 32'hBEA7_0000);

    // Bus error on beat 3.
    clear_logs();
    t0 = cycle_n;
    plan = '{R_ACK, R_ACK, R_ACK, R_ERR};
    plan_refill(32'h0000_4460, plan);
    push_idle(3);
    run_all();
    check("t2_err_count", err_c.size(), 1);
    check("t2_no_we", we_c.size(), 0);
    check("t2_err_lat", err_c.size() > 0 ? err_c[0] - t0 : -1, 5);
    check("t2_fall_lat", fall_c.size() > 0 ? fall_c[0] - t0 : -1, 6);

    // Retry on beat 5.
    clear_logs();
    t0 = cycle_n;
    plan = '{R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_RTY, R_ACK, R_ACK, R_ACK};
    plan_refill(32'h0000_1234, plan);
    push_idle(2);
    run_all();
    check("t3_stb_cycles", adr_log.size(), 9);
    check("t3_retry_adr", adr_log[5], CWF ? 32'h1228 : 32'h1234);
    check("t3_reissue_adr", adr_log[6], CWF ? 32'h1228 : 32'h1234);
    check("t3_we_lat", we_c.size() > 0 ? we_c[0] - t0 : -1, 11);
    check("t3_fall_lat", fall_c.size() > 0 ? fall_c[0] - t0 : -1, 13);

    // Ack and error together on beat 0: abort, buffer untouched.
    clear_logs();
    plan = '{R_ACKERR};
    plan_refill(32'h0000_1234, plan);
    push_idle(2);
    run_all();
    check("t4_err_count", err_c.size(), 1);
    check("t4_no_we", we_c.size(), 0);
    check("t4_line_kept", cache_wdata_o, model_line());
    check("t4_slot_kept", CWF ? cache_wdata_o[191:160] : cache_wdata_o[31:0], 32'hBEA7_0000);

    // Reset asserted during beat 4, then a fresh refill.
    clear_logs();
    plan.delete();
    for (int i = 0; i < 8; i++) plan.push_back(R_ACK);
    plan_refill(32'h0000_5678, plan);
    run_cycles(6);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    stim_q.delete();
    apply_stim('{default: '0});
    for (int i = 0; i < 8; i++) m_buf[i] = '0;
    m_caddr     = '0;
    m_line_ok   = 1;
    prev_freeze = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    push_idle(1);
    t0 = cycle_n + 1;
    plan_refill(32'h0000_9ABC, plan);
    push_idle(2);
    run_all();
    check("t5_we_lat", we_c.size() > 0 ? we_c[0] - t0 : -1, 9);
    check("t5_caddr", we_caddr, 32'h9AA0);

    // Randomized traffic, including back-to-back misses.
    det_data = 0;
    for (int n = 0; n < 60; n++) begin
      push_idle(int'($urandom_range(0, 3)));
      random_plan(plan);
      plan_refill($urandom, plan);
      run_all();
    end
    push_idle(3);
    run_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
